// File: rtl/dmem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dmem_ctrl_pkg
// Shared definitions for the data-memory controller and the CPU top that
// instantiates it: FSM state encoding, default access timeout and the width
// of the timeout counter.
// ---------------------------------------------------------------------------
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } dmem_state_t;

    // Maximum number of ACCESS cycles before an access is aborted.
    localparam int DMEM_TIMEOUT_DEFAULT = 16;

    // Wide enough for the largest legal timeout (255).
    localparam int DMEM_CNT_W = 8;

endpackage

// File: rtl/dmem_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_ctrl_if
// Bundles the CPU-side request bus and the memory-side bus of the data-memory
// controller.
//   slave  : view of the controller (takes CPU requests, drives the memory)
//   master : view of the environment (CPU drives requests, memory responds)
// CPU side   : READ, WRITE, ADDRESS, WRITEDATA -> READDATA, BUSYWAIT, ERROR
// Memory side: MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
//              <- MEM_READDATA, MEM_BUSYWAIT
// ---------------------------------------------------------------------------
interface dmem_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              READ;
    logic              WRITE;
    logic [ADDR_W-1:0] ADDRESS;
    logic [DATA_W-1:0] WRITEDATA;
    logic [DATA_W-1:0] READDATA;
    logic              BUSYWAIT;
    logic              ERROR;

    logic              MEM_READ;
    logic              MEM_WRITE;
    logic [ADDR_W-1:0] MEM_ADDRESS;
    logic [DATA_W-1:0] MEM_WRITEDATA;
    logic [DATA_W-1:0] MEM_READDATA;
    logic              MEM_BUSYWAIT;

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        output READDATA, BUSYWAIT, ERROR,
               MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        input  READDATA, BUSYWAIT, ERROR,
               MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );
endinterface

// File: rtl/dmem_ctrl_timeout_counter.sv
// ---------------------------------------------------------------------------
// timeout_counter
// Counts ACCESS cycles of the data-memory controller.
//   CLK      : clock, rising edge
//   RESET    : synchronous, active-low reset (count -> 0)
//   clear    : load zero (has priority over enable)
//   enable   : increment by one
//   count    : current count (0 in the first ACCESS cycle)
//   terminal : high while count == TC_VALUE-1, i.e. in ACCESS cycle TC_VALUE
// ---------------------------------------------------------------------------
module timeout_counter
    import dmem_ctrl_pkg::*;
#(
    parameter int CNT_W    = DMEM_CNT_W,
    parameter int TC_VALUE = DMEM_TIMEOUT_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count    = count_reg;
    assign terminal = (count_reg == CNT_W'(TC_VALUE - 1));

endmodule

// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl
// Data-memory controller between the CPU load/store unit and a multi-cycle
// memory. A request is latched in IDLE, presented to the memory in ACCESS
// until the memory is ready (or the timeout expires), and released in DONE.
//   CLK   : clock, rising edge
//   RESET : synchronous, active-low reset
//   bus   : dmem_ctrl_if.slave (CPU request bus and memory bus)
// Parameters: ADDR_W, DATA_W, TIMEOUT (2..255 ACCESS cycles)
// ---------------------------------------------------------------------------
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
    input  logic    CLK,
    input  logic    RESET,
    dmem_ctrl_if.slave bus
);

    dmem_state_t state_reg, state_next;

    logic [ADDR_W-1:0]     addr_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [DATA_W-1:0]     rdata_reg;
    logic                  error_reg;
    logic                  mem_read_reg;
    logic                  mem_write_reg;

    logic                  accept;
    logic                  illegal;
    logic                  finish_ok;
    logic                  finish_timeout;
    logic                  busywait_comb;
    logic                  cnt_clear;
    logic                  cnt_enable;
    logic                  cnt_terminal;
    logic [DMEM_CNT_W-1:0] cnt_value;

    timeout_counter #(
        .CNT_W    (DMEM_CNT_W),
        .TC_VALUE (TIMEOUT)
    ) u_timeout (
        .CLK      (CLK),
        .RESET    (RESET),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .count    (cnt_value),
        .terminal (cnt_terminal)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        accept         = 1'b0;
        illegal        = 1'b0;
        finish_ok      = 1'b0;
        finish_timeout = 1'b0;
        busywait_comb  = 1'b0;
        cnt_clear      = 1'b0;
        cnt_enable     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.READ && bus.WRITE) begin
                    illegal = 1'b1;
                end else if (bus.READ || bus.WRITE) begin
                    // Stall the CPU in the request cycle itself.
                    accept        = 1'b1;
                    busywait_comb = 1'b1;
                    cnt_clear     = 1'b1;
                    state_next    = ACCESS;
                end
            end
            ACCESS: begin
                busywait_comb = 1'b1;
                cnt_enable    = 1'b1;
                // The memory has not seen the strobe yet in the first
                // ACCESS cycle, so its busy flag is meaningless there.
                if (cnt_value != '0) begin
                    if (!bus.MEM_BUSYWAIT) begin
                        finish_ok  = 1'b1;
                        state_next = DONE;
                    end else if (cnt_terminal) begin
                        finish_timeout = 1'b1;
                        state_next     = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            error_reg     <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
        end else begin
            if (accept) begin
                addr_reg      <= bus.ADDRESS;
                wdata_reg     <= bus.WRITEDATA;
                mem_read_reg  <= bus.READ;
                mem_write_reg <= bus.WRITE;
            end
            if (finish_ok || finish_timeout) begin
                mem_read_reg  <= 1'b0;
                mem_write_reg <= 1'b0;
            end
            // Only loads ever update READDATA; an aborted load returns
            // all ones so the CPU never consumes stale data silently.
            if (finish_ok && mem_read_reg) begin
                rdata_reg <= bus.MEM_READDATA;
            end
            if (finish_timeout && mem_read_reg) begin
                rdata_reg <= '1;
            end
            if (finish_timeout || illegal) begin
                error_reg <= 1'b1;
            end
        end
    end

    assign bus.BUSYWAIT      = RESET && busywait_comb;
    assign bus.READDATA      = rdata_reg;
    assign bus.ERROR         = error_reg;
    assign bus.MEM_READ      = mem_read_reg;
    assign bus.MEM_WRITE     = mem_write_reg;
    assign bus.MEM_ADDRESS   = addr_reg;
    assign bus.MEM_WRITEDATA = wdata_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_ctrl
// Self-checking bench for dmem_ctrl: directed and random loads/stores against
// a behavioural memory device, with a scoreboard of expected per-access
// results checked by a monitor at each release of BUSYWAIT.
// ---------------------------------------------------------------------------
module tb_dmem_ctrl;

    localparam int TO = 16;

    typedef struct {
        bit         w;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        bit         err;
        int         busy;
        int         strobe;
    } exp_t;

    logic CLK;
    logic RESET;

    dmem_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    dmem_ctrl #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .TIMEOUT (TO)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- memory device ----------------
    logic [7:0] mem_arr [256];
    int         cur_lat = 0;
    int         acc_cyc = 0;

    // Busy for the first cur_lat cycles the strobe is seen, then ready.
    always @(posedge CLK) begin
        #1;
        if (bus.MEM_READ || bus.MEM_WRITE) acc_cyc++;
        else acc_cyc = 0;
        bus.MEM_BUSYWAIT = (acc_cyc != 0) && (acc_cyc <= cur_lat);
        if (acc_cyc != 0 && !bus.MEM_BUSYWAIT && bus.MEM_WRITE)
            mem_arr[bus.MEM_ADDRESS] = bus.MEM_WRITEDATA;
        bus.MEM_READDATA = mem_arr[bus.MEM_ADDRESS];
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [256];
    logic [7:0] exp_rdata = 8'h00;
    bit         exp_error = 1'b0;
    exp_t       exp_q [$];

    // ---------------- monitor ----------------
    int         busy_cnt = 0, rd_cnt = 0, wr_cnt = 0, txn_no = 0;
    bit         prev_busy = 1'b0, latch_moved = 1'b0;
    logic [7:0] seen_addr, seen_wdata;
    exp_t       got;

    always @(negedge CLK) begin
        if (!RESET) begin
            busy_cnt = 0; rd_cnt = 0; wr_cnt = 0;
            prev_busy = 1'b0; latch_moved = 1'b0;
        end else begin
            if (bus.MEM_READ || bus.MEM_WRITE) begin
                if (rd_cnt + wr_cnt == 0) begin
                    seen_addr  = bus.MEM_ADDRESS;
                    seen_wdata = bus.MEM_WRITEDATA;
                end else if (bus.MEM_ADDRESS != seen_addr ||
                             bus.MEM_WRITEDATA != seen_wdata) begin
                    latch_moved = 1'b1;
                end
            end
            rd_cnt += int'(bus.MEM_READ);
            wr_cnt += int'(bus.MEM_WRITE);
            if (bus.BUSYWAIT) begin
                busy_cnt++;
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_release", 1, 0);
                end else begin
                    got = exp_q.pop_front();
                    txn_no++;
                    $display("txn %0d %s addr=%02h data=%02h rdata=%02h err=%0b busy=%0d",
                             txn_no, got.w ? "ST" : "LD", got.addr, got.wdata,
                             bus.READDATA, bus.ERROR, busy_cnt);
                    check("busy_cycles", busy_cnt, got.busy);
                    check("strobe_cycles", got.w ? wr_cnt : rd_cnt, got.strobe);
                    check("wrong_strobe", got.w ? rd_cnt : wr_cnt, 0);
                    check("mem_address", int'(seen_addr), int'(got.addr));
                    if (got.w) check("mem_writedata", int'(seen_wdata), int'(got.wdata));
                    check("latch_stable", int'(latch_moved), 0);
                    check("strobe_in_done", int'(bus.MEM_READ | bus.MEM_WRITE), 0);
                    check("readdata", int'(bus.READDATA), int'(got.rdata));
                    check("error", int'(bus.ERROR), int'(got.err));
                end
                busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; latch_moved = 1'b0;
            end
            prev_busy = bus.BUSYWAIT;
        end
    end

    // ---------------- stimulus ----------------
    // Entered and left at posedge+1; issues one request and holds it until
    // BUSYWAIT falls, scrambling ADDRESS/WRITEDATA once it has been latched.
    task automatic do_req(input bit w, input logic [7:0] a, input logic [7:0] d,
                          input int lat);
        exp_t e;
        int   k;
        bit   to, ok;
        k  = (lat + 1 > 2) ? lat + 1 : 2;
        to = (k > TO);
        e.w = w; e.addr = a; e.wdata = d;
        e.busy   = to ? TO + 1 : k + 1;
        e.strobe = to ? TO : k;
        if (w) begin
            if (!to) ref_mem[a] = d;
        end else begin
            exp_rdata = to ? 8'hFF : ref_mem[a];
        end
        if (to) exp_error = 1'b1;
        e.rdata = exp_rdata;
        e.err   = exp_error;
        exp_q.push_back(e);

        cur_lat = lat;
        bus.ADDRESS = a; bus.WRITEDATA = d;
        bus.READ = !w;   bus.WRITE = w;
        @(posedge CLK); #1;
        bus.ADDRESS = 8'($urandom); bus.WRITEDATA = 8'($urandom);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            if (!bus.BUSYWAIT) begin ok = 1'b1; break; end
        end
        if (!ok) check("busywait_release_timeout", 1, 0);
        bus.READ = 1'b0; bus.WRITE = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 8'($urandom);
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[8'h1A] = 8'h5C; ref_mem[8'h1A] = 8'h5C;
        bus.MEM_BUSYWAIT = 1'b0; bus.MEM_READDATA = 8'h00;

        // Reset with a request pending: BUSYWAIT must stay low.
        RESET = 1'b0;
        bus.READ = 1'b1; bus.WRITE = 1'b0;
        bus.ADDRESS = 8'h55; bus.WRITEDATA = 8'h66;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busywait", int'(bus.BUSYWAIT), 0);
        check("rst_readdata", int'(bus.READDATA), 0);
        check("rst_error", int'(bus.ERROR), 0);
        check("rst_mem_read", int'(bus.MEM_READ), 0);
        check("rst_mem_write", int'(bus.MEM_WRITE), 0);
        check("rst_mem_address", int'(bus.MEM_ADDRESS), 0);
        check("rst_mem_writedata", int'(bus.MEM_WRITEDATA), 0);
        bus.READ = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;

        // Load 0x1A, memory busy 3 cycles, returns 0x5C.
        do_req(1'b0, 8'h1A, 8'h00, 3);
        // Store 0xA7 to 0x03, memory ready at once.
        do_req(1'b1, 8'h03, 8'hA7, 0);
        // Load with memory stuck busy -> timeout, then a normal load.
        do_req(1'b0, 8'h40, 8'h00, 1000);
        do_req(1'b0, 8'h03, 8'h00, 1);

        // Reset in the second ACCESS cycle of a load.
        cur_lat = 5;
        bus.ADDRESS = 8'h1A; bus.READ = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("midrst_busywait", int'(bus.BUSYWAIT), 0);
        @(posedge CLK); #1;
        check("midrst_mem_read", int'(bus.MEM_READ), 0);
        check("midrst_readdata", int'(bus.READDATA), 0);
        check("midrst_error", int'(bus.ERROR), 0);
        bus.READ = 1'b0;
        RESET = 1'b1;
        exp_rdata = 8'h00; exp_error = 1'b0;
        @(posedge CLK); #1;

        // Illegal request: both READ and WRITE in IDLE.
        bus.READ = 1'b1; bus.WRITE = 1'b1;
        @(negedge CLK);
        check("illegal_busywait", int'(bus.BUSYWAIT), 0);
        @(posedge CLK); #1;
        check("illegal_mem_strobe", int'(bus.MEM_READ | bus.MEM_WRITE), 0);
        check("illegal_error", int'(bus.ERROR), 1);
        bus.READ = 1'b0; bus.WRITE = 1'b0;
        exp_error = 1'b1;
        @(posedge CLK); #1;
        do_req(1'b0, 8'h1A, 8'h00, 0);

        // Back-to-back load then store, then a random mix.
        do_req(1'b0, 8'h03, 8'h00, 2);
        do_req(1'b1, 8'h1A, 8'h3C, 1);
        for (int n = 0; n < 60; n++) begin
            bit         w;
            logic [7:0] a;
            int         lat;
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 15));
            if (w) lat = $urandom_range(0, 8);
            else   lat = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 20)
                                                     : $urandom_range(0, 6);
            do_req(w, a, 8'($urandom), lat);
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK); #1;
            end
        end

        repeat (2) @(posedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
